// File: rtl/td4_run_ctrl.sv
// ---------------------------------------------------------------------------
// td4_run_ctrl
//
// Run/load controller for a TD4-style 4-bit CPU. It loads a program into the
// CPU's program memory through a valid/ready word stream. It then releases
// the CPU from reset and gates its clock enable for free-running or
// single-step execution. With HALT_DETECT set, it halts automatically on a
// jump-to-self.
//
// Handshake (load stream): a word transfers on a rising clk edge where
// ld_valid=1 and ld_ready=1. The source must hold ld_opcode/ld_imm stable
// while ld_valid=1. ld_ready is registered and is 1 for the whole LOAD state.
//
// Parameters
//   HALT_DETECT : 1 enables self-loop halt detection in RUN
//   PROG_WORDS  : words per full load, 1..16
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   load_start              : pulse, begin loading at address 0
//   ld_valid/ld_opcode/ld_imm/ld_ready : load word stream
//   run_go, step_req, stop_req : control pulses
//   pc                      : CPU program counter (for halt detection)
//   cpu_en, cpu_rst_n       : CPU clock enable and active-low reset
//   mem_we/mem_addr/mem_opcode/mem_imm : program memory write port
//   loaded_cnt              : words written by the last load (0..16)
//   state                   : IDLE=0 LOAD=1 RUN=2 STEP=3 HALT=4 (debug/observe)
//
// All outputs are registered. Pulse priority within one cycle is
// load_start > stop_req > run_go > step_req.
// ---------------------------------------------------------------------------
module td4_run_ctrl #(
  parameter int HALT_DETECT = 1,
  parameter int PROG_WORDS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       ld_valid,
  input  logic [3:0] ld_opcode,
  input  logic [3:0] ld_imm,
  output logic       ld_ready,
  input  logic       run_go,
  input  logic       step_req,
  input  logic       stop_req,
  input  logic [3:0] pc,
  output logic       cpu_en,
  output logic       cpu_rst_n,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_opcode,
  output logic [3:0] mem_imm,
  output logic [4:0] loaded_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  // loaded_cnt value at which the accepted word is the last one of a full load
  localparam logic [4:0] LAST_IDX = 5'(PROG_WORDS - 1);

  state_t     state_q;
  // pc samples from the two previous enabled RUN cycles; pc_hist_cnt says
  // how many of them are valid since RUN was entered (saturates at 2)
  logic [3:0] pc_h1;
  logic [3:0] pc_h2;
  logic [1:0] pc_hist_cnt;
  logic       self_loop;

  // A jump-to-self shows up as the same pc on three consecutive enabled
  // cycles, i.e. pc unchanged across two enabled cycles in a row.
  assign self_loop = (HALT_DETECT != 0) && (pc_hist_cnt == 2'd2) &&
                     (pc == pc_h1) && (pc_h1 == pc_h2);

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cpu_en      <= 1'b0;
      cpu_rst_n   <= 1'b0;
      ld_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 4'd0;
      mem_opcode  <= 4'd0;
      mem_imm     <= 4'd0;
      loaded_cnt  <= 5'd0;
      pc_h1       <= 4'd0;
      pc_h2       <= 4'd0;
      pc_hist_cnt <= 2'd0;
    end else begin
      // write strobe is a single-cycle pulse after each accepted word
      mem_we <= 1'b0;

      if (load_start) begin
        // load_start wins from any state and restarts the load from scratch
        state_q    <= ST_LOAD;
        cpu_en     <= 1'b0;
        cpu_rst_n  <= 1'b0;
        ld_ready   <= 1'b1;
        loaded_cnt <= 5'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // stop_req outranks run_go/step_req, so it blocks both here
            if (!stop_req && loaded_cnt != 5'd0) begin
              if (run_go) begin
                state_q     <= ST_RUN;
                cpu_en      <= 1'b1;
                cpu_rst_n   <= 1'b1;
                pc_hist_cnt <= 2'd0;
              end else if (step_req) begin
                state_q   <= ST_STEP;
                cpu_en    <= 1'b1;
                cpu_rst_n <= 1'b1;
              end
            end
          end

          ST_LOAD: begin
            if (ld_valid && ld_ready) begin
              // loaded_cnt doubles as the write address during a load
              mem_we     <= 1'b1;
              mem_addr   <= loaded_cnt[3:0];
              mem_opcode <= ld_opcode;
              mem_imm    <= ld_imm;
              loaded_cnt <= loaded_cnt + 5'd1;
              if (loaded_cnt == LAST_IDX) begin
                ld_ready <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end
            // a word handshaken in the same cycle is still written above
            if (stop_req) begin
              ld_ready <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end

          ST_RUN: begin
            if (stop_req || self_loop) begin
              state_q <= ST_HALT;
              cpu_en  <= 1'b0;
            end else begin
              pc_h1 <= pc;
              pc_h2 <= pc_h1;
              if (pc_hist_cnt != 2'd2) begin
                pc_hist_cnt <= pc_hist_cnt + 2'd1;
              end
            end
          end

          ST_STEP: begin
            // exactly one enabled cycle, whatever else is requested
            state_q <= ST_HALT;
            cpu_en  <= 1'b0;
          end

          ST_HALT: begin
            if (!stop_req) begin
              if (run_go) begin
                state_q     <= ST_RUN;
                cpu_en      <= 1'b1;
                pc_hist_cnt <= 2'd0;
              end else if (step_req) begin
                state_q <= ST_STEP;
                cpu_en  <= 1'b1;
              end
            end
          end

          default: begin
            state_q   <= ST_IDLE;
            cpu_en    <= 1'b0;
            cpu_rst_n <= 1'b0;
            ld_ready  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_td4_run_ctrl
//
// Directed sequence with randomized data, pc streams and gaps. Expected
// values come from a behavioural model: an expected write queue for loads,
// a list of pc samples for halt detection ("last three samples equal"), and
// simple pulse counts for stepping.
// ---------------------------------------------------------------------------
module tb_td4_run_ctrl;

  localparam int PW = 16;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;
  localparam int S_STEP = 3;
  localparam int S_HALT = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [3:0] ld_opcode = 4'd0;
  logic [3:0] ld_imm = 4'd0;
  logic       run_go = 1'b0;
  logic       step_req = 1'b0;
  logic       stop_req = 1'b0;
  logic [3:0] pc = 4'd0;
  logic       ld_ready;
  logic       cpu_en;
  logic       cpu_rst_n;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_opcode;
  logic [3:0] mem_imm;
  logic [4:0] loaded_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  td4_run_ctrl #(.HALT_DETECT(1), .PROG_WORDS(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_opcode  (ld_opcode),
    .ld_imm     (ld_imm),
    .ld_ready   (ld_ready),
    .run_go     (run_go),
    .step_req   (step_req),
    .stop_req   (stop_req),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .cpu_rst_n  (cpu_rst_n),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_opcode (mem_opcode),
    .mem_imm    (mem_imm),
    .loaded_cnt (loaded_cnt),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          en_pulses = 0;
  int          model_cnt = 0;
  logic [11:0] exp_q[$];     // {addr, opcode, imm} of expected writes
  logic [3:0]  pc_seq[$];    // pc stream for the next run

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // all request pulses and ld_valid are dropped again.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_en) en_pulses++;
    load_start = 1'b0;
    run_go     = 1'b0;
    step_req   = 1'b0;
    stop_req   = 1'b0;
    ld_valid   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, S_IDLE);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_cpu_en"}, cpu_en, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_word"}, {mem_addr, mem_opcode, mem_imm}, 0);
    chk({tag, "_loaded_cnt"}, loaded_cnt, 0);
  endtask

  // Load n words; random data with random idle gaps, or the opcode=i,
  // imm=15-i pattern back to back. With abort, finish with stop_req.
  task automatic do_load(input int n, input bit rand_data, input bit abort);
    logic [3:0]  op;
    logic [3:0]  im;
    logic [11:0] w;
    load_start = 1'b1;
    tick();
    model_cnt = 0;
    chk("load_enter_state", state, S_LOAD);
    chk("load_enter_ready", ld_ready, 1);
    chk("load_enter_cnt", loaded_cnt, 0);
    chk("load_cpu_rst_n", cpu_rst_n, 0);
    for (int i = 0; i < n; i++) begin
      if (rand_data && $urandom_range(0, 3) == 0) begin
        tick();
        chk("load_gap_we", mem_we, 0);
        chk("load_gap_ready", ld_ready, 1);
      end
      op = rand_data ? 4'($urandom) : 4'(i);
      im = rand_data ? 4'($urandom) : 4'(15 - i);
      ld_valid  = 1'b1;
      ld_opcode = op;
      ld_imm    = im;
      exp_q.push_back({4'(i), op, im});
      model_cnt++;
      tick();
      w = exp_q.pop_front();
      chk("load_we", mem_we, 1);
      chk("load_word", {mem_addr, mem_opcode, mem_imm}, w);
      chk("load_cnt", loaded_cnt, model_cnt);
      chk("load_cpu_en", cpu_en, 0);
    end
    if (n == PW) begin
      chk("load_done_state", state, S_IDLE);
      chk("load_done_ready", ld_ready, 0);
    end else if (abort) begin
      stop_req = 1'b1;
      tick();
      chk("abort_state", state, S_IDLE);
      chk("abort_ready", ld_ready, 0);
      chk("abort_we", mem_we, 0);
      chk("abort_cnt", loaded_cnt, n);
    end
    tick();
    chk("load_post_we", mem_we, 0);
    chk("load_post_cnt", loaded_cnt, model_cnt);
  endtask

  // Start a run and feed pc_seq; the model halts once the last three pc
  // samples taken in enabled RUN cycles are equal.
  task automatic run_seq();
    int hist[$];
    bit halted;
    halted = 1'b0;
    run_go = 1'b1;
    tick();
    chk("run_enter_state", state, S_RUN);
    chk("run_enter_en", cpu_en, 1);
    chk("run_enter_rst_n", cpu_rst_n, 1);
    foreach (pc_seq[k]) begin
      if (!halted) begin
        pc = pc_seq[k];
        tick();
        hist.push_back(int'(pc_seq[k]));
        halted = (hist.size() >= 3) && (hist[$] == hist[$-1]) && (hist[$-1] == hist[$-2]);
        chk("run_state", state, halted ? S_HALT : S_RUN);
        chk("run_en", cpu_en, halted ? 0 : 1);
      end
    end
    chk("run_halted", halted, 1);
    chk("run_halt_rst_n", cpu_rst_n, 1);
  endtask

  // Run with a strictly changing pc (no self loop), then stop_req.
  task automatic run_then_stop(input int cycles);
    run_go = 1'b1;
    tick();
    chk("rs_enter_state", state, S_RUN);
    for (int i = 0; i < cycles; i++) begin
      pc = 4'(i);
      step_req = 1'($urandom_range(0, 1));   // must be ignored in RUN
      tick();
      chk("rs_state", state, S_RUN);
      chk("rs_en", cpu_en, 1);
    end
    stop_req = 1'b1;
    tick();
    chk("rs_stop_state", state, S_HALT);
    chk("rs_stop_en", cpu_en, 0);
    chk("rs_stop_rst_n", cpu_rst_n, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset values
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // run/step with nothing loaded are ignored
    run_go = 1'b1;
    tick();
    chk("empty_run_state", state, S_IDLE);
    chk("empty_run_en", cpu_en, 0);
    step_req = 1'b1;
    tick();
    chk("empty_step_state", state, S_IDLE);

    // full back-to-back load
    do_load(PW, 1'b0, 1'b0);

    // self-loop halt: 0,1,2,3,3,3
    pc_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    run_seq();

    // three single steps from HALT
    en_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      chk("step_state", state, S_STEP);
      chk("step_en", cpu_en, 1);
      tick();
      chk("step_back_state", state, S_HALT);
      chk("step_back_en", cpu_en, 0);
      tick();
    end
    chk("step_pulses", en_pulses, 3);

    // run_go during STEP is ignored
    step_req = 1'b1;
    tick();
    run_go = 1'b1;
    tick();
    chk("step_run_ignored", state, S_HALT);

    // stop_req + run_go from HALT stays in HALT
    run_then_stop($urandom_range(2, 6));
    stop_req = 1'b1;
    run_go   = 1'b1;
    tick();
    chk("prio_stop_state", state, S_HALT);
    chk("prio_stop_en", cpu_en, 0);

    // load_start + run_go from HALT enters LOAD, then abort with no words
    load_start = 1'b1;
    run_go     = 1'b1;
    tick();
    chk("prio_load_state", state, S_LOAD);
    chk("prio_load_rst_n", cpu_rst_n, 0);
    chk("prio_load_en", cpu_en, 0);
    stop_req = 1'b1;
    tick();
    chk("empty_abort_state", state, S_IDLE);
    chk("empty_abort_cnt", loaded_cnt, 0);
    run_go = 1'b1;
    tick();
    chk("empty_abort_run", state, S_IDLE);

    // aborted random load of 5 words, then run_go works
    do_load(5, 1'b1, 1'b1);
    run_then_stop(3);

    // aborted load of random length, then a random pc stream
    do_load($urandom_range(1, PW - 1), 1'b1, 1'b1);
    pc_seq.delete();
    for (int i = 0; i < 10; i++) pc_seq.push_back(4'($urandom_range(0, 3)));
    begin
      logic [3:0] v;
      v = 4'($urandom);
      repeat (3) pc_seq.push_back(v);
    end
    run_seq();

    // step directly from IDLE after a load
    do_load(PW, 1'b1, 1'b0);
    step_req = 1'b1;
    tick();
    chk("idle_step_state", state, S_STEP);
    chk("idle_step_rst_n", cpu_rst_n, 1);
    tick();
    chk("idle_step_halt", state, S_HALT);

    // reset mid-run
    run_go = 1'b1;
    tick();
    pc = 4'd5;
    tick();
    pc = 4'd6;
    tick();
    chk("pre_reset_state", state, S_RUN);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_run_now");
    tick();
    tick();
    chk_reset_vals("reset_run_held");
    rst_n = 1'b1;
    run_go = 1'b1;
    tick();
    chk("post_reset_run_state", state, S_IDLE);
    chk("post_reset_run_en", cpu_en, 0);

    // reset mid-load: no further write pulse
    load_start = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_opcode = 4'($urandom);
    ld_imm = 4'($urandom);
    tick();
    chk("ml_first_we", mem_we, 1);
    ld_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_load_now");
    tick();
    chk("reset_load_no_we", mem_we, 0);
    rst_n = 1'b1;
    tick();
    chk("reset_load_idle", state, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter HALT_DETECT, default 1: 1 enables self-loop halt detection, 0 disables it.
REQ-002 SHALL have parameter PROG_WORDS, default 16: number of program words per load, legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_start, input, 1 bit: single-cycle pulse that begins a program load at address 0.
REQ-006 SHALL have port ld_valid, input, 1 bit: a load word is present.
REQ-007 SHALL have port ld_opcode, input, 4 bits: opcode of the load word.
REQ-008 SHALL have port ld_imm, input, 4 bits: immediate of the load word.
REQ-009 SHALL have port ld_ready, output, 1 bit: the controller accepts the load word.
REQ-010 SHALL have port run_go, input, 1 bit: pulse that starts free-running execution.
REQ-011 SHALL have port step_req, input, 1 bit: pulse that executes exactly one CPU cycle.
REQ-012 SHALL have port stop_req, input, 1 bit: pulse that stops execution or aborts a load.
REQ-013 SHALL have port pc, input, 4 bits: current program counter of the CPU.
REQ-014 SHALL have port cpu_en, output, 1 bit: CPU clock enable.
REQ-015 SHALL have port cpu_rst_n, output, 1 bit: active-low CPU reset.
REQ-016 SHALL have ports mem_we (1 bit), mem_addr (4 bits), mem_opcode (4 bits) and mem_imm (4 bits), all outputs: program memory write port.
REQ-017 SHALL have port loaded_cnt, output, 5 bits: number of words written by the last load.
REQ-018 SHALL have port state, output, 3 bits: state encoding IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.

Function
REQ-019 SHALL register every output; no combinational path from any input to any output.
REQ-020 SHALL give load_start the highest priority, then stop_req, then run_go, then step_req, when pulses arrive in the same cycle.
REQ-021 IDLE: cpu_rst_n=0, cpu_en=0.
  - load_start -> LOAD.
  - run_go with loaded_cnt>0 -> RUN.
  - step_req with loaded_cnt>0 -> STEP.
  - run_go or step_req with loaded_cnt=0 -> ignored.
REQ-022 On entering LOAD, SHALL clear the write address and loaded_cnt to 0, and drive ld_ready=1 from the next cycle onward.
REQ-023 LOAD handshake: a word transfers in a cycle where ld_valid=1 and ld_ready=1.
  - Next cycle: mem_we=1 for one cycle, mem_addr=current address, mem_opcode/mem_imm=captured word.
  - Address and loaded_cnt increment by 1.
REQ-024 LOAD SHALL hold cpu_rst_n=0 and cpu_en=0 for its whole duration.
REQ-025 Load completion: after the PROG_WORDS-th transfer, ld_ready drops in the same cycle as the final mem_we pulse and the state moves to IDLE.
  - Address does not wrap.
  - Transfers beyond PROG_WORDS are impossible.
REQ-026 stop_req in LOAD -> IDLE next cycle.
  - A write already accepted still completes.
  - loaded_cnt keeps the partial count.
REQ-027 Entry to RUN or STEP from IDLE SHALL drive cpu_rst_n=1 in the same cycle cpu_en first becomes 1, i.e. one cycle after the request.
REQ-028 RUN: cpu_en=1 every cycle.
  - stop_req -> HALT, with cpu_en=0 in the following cycle.
REQ-029 With HALT_DETECT=1, RUN -> HALT when pc is unchanged across two consecutive enabled cycles (jump to self); cpu_en=0 from the next cycle.
REQ-030 STEP: cpu_en=1 for exactly one cycle, then HALT.
REQ-031 HALT: cpu_en=0, cpu_rst_n=1.
  - run_go -> RUN.
  - step_req -> STEP.
  - load_start -> LOAD, which drives cpu_rst_n=0.
REQ-032 In RUN, step_req SHALL be ignored; in STEP and LOAD, run_go SHALL be ignored.
REQ-033 mem_we SHALL be 0 in every state other than the cycle following a LOAD transfer.

Reset
REQ-034 While rst_n=0, outputs SHALL be:
  - state=IDLE, cpu_rst_n=0, cpu_en=0, ld_ready=0, mem_we=0.
  - mem_addr=0, mem_opcode=0, mem_imm=0, loaded_cnt=0.
  - The halt-detect pc history is cleared.
REQ-035 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately with no further mem_we pulse; operation resumes only on a new load_start.

Verification
REQ-036 Full load: load_start, then 16 back-to-back ld_valid words (opcode=i, imm=15-i) -> 16 mem_we pulses at addr 0..15 with matching data, loaded_cnt=16, state=IDLE.
REQ-037 Self-loop halt: after load, run_go; pc sequence 0,1,2,3,3,3 -> state=HALT, with cpu_en low starting the cycle after the second repeated 3.
REQ-038 Single step: from HALT, step_req -> exactly one cycle with cpu_en=1, then state=HALT; repeated 3 times gives exactly 3 enable pulses.
REQ-039 Aborted load: load_start, 5 words, stop_req -> loaded_cnt=5, state=IDLE, no further mem_we; run_go then yields RUN.
REQ-040 Priority: load_start and run_go in the same cycle from HALT -> LOAD with cpu_rst_n=0; stop_req and run_go in the same cycle from HALT -> stays HALT.
REQ-041 Reset mid-run: rst_n low for 2 cycles during RUN -> all outputs at reset values; run_go afterwards with loaded_cnt=0 is ignored.
